// File: rtl/clock_gen.sv
// Multi-ratio clock generator: power-of-two, /26, /3, /5 and strobe-driven dividers.
// Define TOGGLE_COUNTER_EN to build the strobe-modulated toggle_counter; otherwise it reads 0.
module clock_gen (
  input  logic       clk_in,
  input  logic       rst,
  output logic       clk_div_2,
  output logic       clk_div_4,
  output logic       clk_div_8,
  output logic       clk_div_16,
  output logic       clk_div_32,
  output logic       clk_div_26,
  output logic       clk_pos,
  output logic       clk_neg,
  output logic       clk_div_3,
  output logic       clk_div_5,
  output logic       clk_div,
  output logic [7:0] toggle_counter
);

  logic [4:0] cnt_q;
  logic [3:0] cnt26_q;
  logic       div26_q;
  logic [1:0] cnt3_q, cnt3_d;
  logic       pos3_q, neg3_q;
  logic [2:0] cnt5_q, cnt5_d;
  logic       pos5_q, neg5_q;
  logic [1:0] cnt4_q;
  logic       strobe;
  logic       div_q;

  always_comb begin
    cnt3_d = (cnt3_q == 2'd2) ? 2'd0 : cnt3_q + 2'd1;
    cnt5_d = (cnt5_q == 3'd4) ? 3'd0 : cnt5_q + 3'd1;
    strobe = (cnt4_q == 2'd3);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      cnt26_q <= '0;
      div26_q <= 1'b0;
      cnt3_q  <= '0;
      pos3_q  <= 1'b0;
      cnt5_q  <= '0;
      pos5_q  <= 1'b0;
      cnt4_q  <= '0;
      div_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 5'd1;
      if (cnt26_q == 4'd12) begin
        cnt26_q <= '0;
        div26_q <= ~div26_q;
      end else begin
        cnt26_q <= cnt26_q + 4'd1;
      end
      cnt3_q <= cnt3_d;
      pos3_q <= (cnt3_d == 2'd0);
      cnt5_q <= cnt5_d;
      // High for the two cycles following the wrap to 0.
      pos5_q <= (cnt5_d == 3'd0) || (cnt5_d == 3'd1);
      cnt4_q <= cnt4_q + 2'd1;
      if (strobe) div_q <= ~div_q;
    end
  end

  // Half-period-delayed copies widen the odd-ratio pulses to 50% duty.
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) begin
      neg3_q <= 1'b0;
      neg5_q <= 1'b0;
    end else begin
      neg3_q <= pos3_q;
      neg5_q <= pos5_q;
    end
  end

`ifdef TOGGLE_COUNTER_EN
  logic [7:0] tc_q;
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)        tc_q <= '0;
    else if (strobe) tc_q <= tc_q - 8'd5;
    else             tc_q <= tc_q + 8'd2;
  end
  assign toggle_counter = tc_q;
`else
  assign toggle_counter = 8'd0;
`endif

  assign clk_div_2  = cnt_q[0];
  assign clk_div_4  = cnt_q[1];
  assign clk_div_8  = cnt_q[2];
  assign clk_div_16 = cnt_q[3];
  assign clk_div_32 = cnt_q[4];
  assign clk_div_26 = div26_q;
  assign clk_pos    = pos3_q;
  assign clk_neg    = neg3_q;
  assign clk_div_3  = pos3_q | neg3_q;
  assign clk_div_5  = pos5_q | neg5_q;
  assign clk_div    = div_q;

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen: closed-form edge model via a scoreboard queue,
// plus a table of spot checks at specific edges after each reset release.
module tb_clock_gen;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       clk_div_2, clk_div_4, clk_div_8, clk_div_16, clk_div_32;
  logic       clk_div_26, clk_pos, clk_neg, clk_div_3, clk_div_5, clk_div;
  logic [7:0] toggle_counter;

  clock_gen dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .clk_div_2     (clk_div_2),
    .clk_div_4     (clk_div_4),
    .clk_div_8     (clk_div_8),
    .clk_div_16    (clk_div_16),
    .clk_div_32    (clk_div_32),
    .clk_div_26    (clk_div_26),
    .clk_pos       (clk_pos),
    .clk_neg       (clk_neg),
    .clk_div_3     (clk_div_3),
    .clk_div_5     (clk_div_5),
    .clk_div       (clk_div),
    .toggle_counter(toggle_counter)
  );

  always #5 clk_in = ~clk_in;

  // Output bit order: 10 clk_div, 9 div5, 8 div3, 7 neg, 6 pos, 5 div26, 4..0 div32..div2
  typedef struct {
    logic [10:0] outs;
    logic [7:0]  tc;
    string       tag;
  } exp_t;

  typedef struct {
    int    n;
    int    idx;
    logic  val;
    string name;
  } vec_t;

  typedef struct {
    int         n;
    logic [7:0] val;
  } tc_vec_t;

  exp_t    sb[$];
  vec_t    vt[15];
  tc_vec_t tt[5];
  int      tests = 0;
  int      fails = 0;
  int      n = 0;

  function automatic logic p3(int k);
    return (k > 0) && (k % 3 == 0);
  endfunction

  function automatic logic p5(int k);
    return (k > 0) && ((k % 5 == 0) || (k % 5 == 1));
  endfunction

  // Expected outputs after edge k; lo selects the sample taken after the following fall.
  function automatic exp_t model(int k, bit lo);
    exp_t       e;
    logic       pos, neg, q5, c5;
    logic [4:0] m;
    m   = 5'(k % 32);
    pos = p3(k);
    neg = lo ? p3(k) : p3(k - 1);
    q5  = p5(k);
    c5  = lo ? p5(k) : p5(k - 1);
    e.outs = {((k / 4) % 2 == 1), q5 | c5, pos | neg, neg, pos, ((k / 13) % 2 == 1), m};
`ifdef TOGGLE_COUNTER_EN
    e.tc = 8'((2 * (k - k / 4) - 5 * (k / 4)) % 256);
`else
    e.tc = 8'd0;
`endif
    e.tag = lo ? "lo" : "hi";
    return e;
  endfunction

  function automatic logic [10:0] dut_outs();
    return {clk_div, clk_div_5, clk_div_3, clk_neg, clk_pos, clk_div_26,
            clk_div_32, clk_div_16, clk_div_8, clk_div_4, clk_div_2};
  endfunction

  task automatic compare(string name, logic [18:0] act, logic [18:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s edge=%0d actual=%h required=%h", name, n, act, req);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk_in);
    n++;
    sb.push_back(model(n, 1'b0));
    #1;
    e = sb.pop_front();
    compare({"edge_", e.tag}, {dut_outs(), toggle_counter}, {e.outs, e.tc});
    for (int i = 0; i < 15; i++) begin
      if (vt[i].n == n) compare(vt[i].name, 19'(dut_outs()[vt[i].idx]), 19'(vt[i].val));
    end
    for (int i = 0; i < 5; i++) begin
      if (tt[i].n == n) compare("toggle_counter", 19'(toggle_counter), 19'(tt[i].val));
    end
    @(negedge clk_in);
    sb.push_back(model(n, 1'b1));
    #1;
    e = sb.pop_front();
    compare({"edge_", e.tag}, {dut_outs(), toggle_counter}, {e.outs, e.tc});
  endtask

  initial begin
    vt[0]  = '{1, 0, 1'b1, "div2_e1"};
    vt[1]  = '{2, 1, 1'b1, "div4_e2"};
    vt[2]  = '{2, 0, 1'b0, "div2_e2"};
    vt[3]  = '{15, 4, 1'b0, "div32_e15"};
    vt[4]  = '{16, 4, 1'b1, "div32_e16"};
    vt[5]  = '{12, 5, 1'b0, "div26_e12"};
    vt[6]  = '{13, 5, 1'b1, "div26_e13"};
    vt[7]  = '{26, 5, 1'b0, "div26_e26"};
    vt[8]  = '{39, 5, 1'b1, "div26_e39"};
    vt[9]  = '{3, 6, 1'b1, "pos_e3"};
    vt[10] = '{4, 6, 1'b0, "pos_e4"};
    vt[11] = '{4, 7, 1'b1, "neg_before_fall_e4"};
    vt[12] = '{4, 10, 1'b1, "clk_div_e4"};
    vt[13] = '{8, 10, 1'b0, "clk_div_e8"};
    vt[14] = '{5, 9, 1'b1, "div5_e5"};
`ifdef TOGGLE_COUNTER_EN
    tt[0] = '{1, 8'd2};
    tt[1] = '{2, 8'd4};
    tt[2] = '{3, 8'd6};
    tt[3] = '{4, 8'd1};
    tt[4] = '{8, 8'd2};
`else
    tt[0] = '{1, 8'd0};
    tt[1] = '{2, 8'd0};
    tt[2] = '{3, 8'd0};
    tt[3] = '{4, 8'd0};
    tt[4] = '{8, 8'd0};
`endif

    rst = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    #1;
    compare("reset_hold", {dut_outs(), toggle_counter}, 19'd0);
    #1 rst = 1'b1;
    #1;
    compare("released_before_edge1", {dut_outs(), toggle_counter}, 19'd0);
    n = 0;
    repeat (20) step();

    // Short pulse in the low phase after edge 20.
    rst = 1'b0;
    #1;
    compare("midrun_reset", {dut_outs(), toggle_counter}, 19'd0);
    #1 rst = 1'b1;
    #1;
    compare("midrun_released", {dut_outs(), toggle_counter}, 19'd0);
    n = 0;
    // Long enough for toggle_counter to wrap past 255.
    repeat (1100) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
